seg7_scan_driver: RTL and testbench

//  Output-side counterpart of the push-button input path: takes the 8-bit trigger count and the mode bit,

---
 rtl/seg7_pkg.sv | 59 +++++
 rtl/seg7_scan_driver_bin2bcd.sv | 84 ++++++++
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment scan driver
// Contents: conversion FSM state encoding, active-low segment patterns
// ({g,f,e,d,c,b,a}), digit index constants and small datapath helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam int BIN_W       = 8;
    localparam int BCD_W       = 12;
    localparam int SHIFT_STEPS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h10;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_MODE     = 2'd3;

    // Nibbles above 9 cannot occur from the converter; they fall back to blank.
    function automatic logic [6:0] seg_of_nibble(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = SEG_DIGIT_0;
            4'd1:    s = SEG_DIGIT_1;
            4'd2:    s = SEG_DIGIT_2;
            4'd3:    s = SEG_DIGIT_3;
            4'd4:    s = SEG_DIGIT_4;
            4'd5:    s = SEG_DIGIT_5;
            4'd6:    s = SEG_DIGIT_6;
            4'd7:    s = SEG_DIGIT_7;
            4'd8:    s = SEG_DIGIT_8;
            4'd9:    s = SEG_DIGIT_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction applied to each BCD nibble before every shift.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// rtl/seg7_scan_driver_bin2bcd.sv - sequential 8-bit binary to 3-digit BCD converter
// Ports:
//   clk   in   1   clock
//   rst   in   1   synchronous active-high reset (aborts a conversion)
//   start in   1   begin a conversion of bin (honoured in IDLE only)
//   bin   in   8   binary value captured on start
//   busy  out  1   high in SHIFT and COMMIT
//   done  out  1   high for the single COMMIT cycle; bcd is final then
//   bcd   out  12  {hundreds, tens, ones} scratch register
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_W-1:0]     bcd
);

    conv_state_t r_state;
    conv_state_t w_state_next;

    logic [BIN_W-1:0]         r_bin;
    logic [BCD_W-1:0]         r_scratch;
    logic [2:0]               r_count;
    logic [BCD_W-1:0]         w_adjusted;
    logic [BCD_W+BIN_W-1:0]   w_shifted;

    always_comb begin
        w_adjusted = {add3_if_ge5(r_scratch[11:8]),
                      add3_if_ge5(r_scratch[7:4]),
                      add3_if_ge5(r_scratch[3:0])};
        // Bits shifted out of the top are always zero for inputs <= 255.
        w_shifted  = {w_adjusted, r_bin} << 1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (r_count == 3'(SHIFT_STEPS - 1)) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin     <= bin;
                        r_scratch <= '0;
                        r_count   <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_scratch, r_bin} <= w_shifted;
                    r_count            <= r_count + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_COMMIT);
    assign bcd  = r_scratch;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - BCD conversion and 4-digit common-anode 7-segment scanning
// Ports:
//   clk   in   1   system clock
//   rst   in   1   synchronous active-high reset
//   value in   8   binary count to display
//   mode  in   1   mode indicator shown on digit 3 ('-' when 1, blank when 0)
//   an    out  4   digit enables, active-low
//   seg   out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp    out  1   decimal point, active-low, held off
//   busy  out  1   conversion in progress
// Parameter REFRESH_DIV: clock cycles each digit stays lit (>= 2).
// Build option LEADING_ZERO_BLANK_EN: blank leading zero hundreds/tens digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [7:0]       r_captured;
    logic [3:0]       r_hundreds;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [CNT_W-1:0] r_refresh;
    logic [1:0]       r_index;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [11:0]      w_bcd;
    logic             w_wrap;
    logic [1:0]       w_index_next;
    logic [3:0]       w_hundreds_next;
    logic [3:0]       w_tens_next;
    logic [3:0]       w_ones_next;
    logic             w_blank_hundreds;
    logic             w_blank_tens;
    logic [6:0]       w_seg_next;

    // A new conversion is only launched from IDLE; changes seen while busy
    // are picked up by this compare once the converter returns to IDLE.
    assign w_start = !w_busy && (value != r_captured);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (value),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    assign w_wrap       = (r_refresh == CNT_W'(REFRESH_DIV - 1));
    assign w_index_next = w_wrap ? (r_index + 2'd1) : r_index;

    // Output registers are loaded from next-state digit data so a commit and
    // a digit advance on the same edge show the new value on the new digit,
    // and an/seg always switch together.
    assign w_hundreds_next = w_done ? w_bcd[11:8] : r_hundreds;
    assign w_tens_next     = w_done ? w_bcd[7:4]  : r_tens;
    assign w_ones_next     = w_done ? w_bcd[3:0]  : r_ones;

    always_comb begin
        w_blank_hundreds = 1'b0;
        w_blank_tens     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_hundreds = (w_hundreds_next == 4'd0);
        w_blank_tens     = (w_hundreds_next == 4'd0) && (w_tens_next == 4'd0);
`else
        w_blank_hundreds = 1'b0;
        w_blank_tens     = 1'b0;
`endif
    end

    always_comb begin
        w_seg_next = SEG_BLANK;
        case (w_index_next)
            DIG_ONES:     w_seg_next = seg_of_nibble(w_ones_next);
            DIG_TENS:     w_seg_next = w_blank_tens ? SEG_BLANK : seg_of_nibble(w_tens_next);
            DIG_HUNDREDS: w_seg_next = w_blank_hundreds ? SEG_BLANK : seg_of_nibble(w_hundreds_next);
            DIG_MODE:     w_seg_next = mode ? SEG_DASH : SEG_BLANK;
            default:      w_seg_next = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_captured <= '0;
        end else if (w_start) begin
            r_captured <= value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hundreds <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
        end else begin
            r_hundreds <= w_hundreds_next;
            r_tens     <= w_tens_next;
            r_ones     <= w_ones_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_index   <= DIG_ONES;
        end else begin
            r_refresh <= w_wrap ? '0 : (r_refresh + 1'b1);
            r_index   <= w_index_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << w_index_next);
            r_seg <= w_seg_next;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign busy = w_busy;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       mode;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int vectors;
    int miscompares;
    int k;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } bcd_t;

    bcd_t q_exp[$];
    logic [3:0] m_h, m_t, m_o;

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .mode  (mode),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; selects the digit the display should be on.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (n < 4'd10) ? t[n] : 7'h7F;
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        logic [6:0] s;
        case (idx)
            0: s = pat(m_o);
`ifdef LEADING_ZERO_BLANK_EN
            1: s = (m_h == 0 && m_t == 0) ? 7'h7F : pat(m_t);
            2: s = (m_h == 0) ? 7'h7F : pat(m_h);
`else
            1: s = pat(m_t);
            2: s = pat(m_h);
`endif
            default: s = mode ? 7'h3F : 7'h7F;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_scan(input string tag);
        int idx;
        idx = (k / DIV) % 4;
        chk({tag, "_an"}, 32'(an), 32'(~(4'b0001 << idx) & 4'hF));
        chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(idx)));
        chk({tag, "_dp"}, 32'(dp), 32'd1);
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) begin
            step();
            chk_scan(tag);
        end
    endtask

    task automatic drive_value(input logic [7:0] v);
        bcd_t e;
        value = v;
        e.h = 4'(v / 100);
        e.t = 4'((v / 10) % 10);
        e.o = 4'(v % 10);
        q_exp.push_back(e);
    endtask

    task automatic pop_result(input string tag);
        bcd_t e;
        chk({tag, "_q_nonempty"}, 32'(q_exp.size() != 0), 32'd1);
        if (q_exp.size() != 0) begin
            e   = q_exp.pop_front();
            m_h = e.h;
            m_t = e.t;
            m_o = e.o;
        end
    endtask

    // Value (or release of reset) was set just before the next edge E0:
    // busy high after E0..E8, low after E9, new digits visible after E9.
    task automatic run_conversion(input string tag);
        for (int i = 0; i < 9; i++) begin
            step();
            chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
            chk_scan({tag, "_hold"});
        end
        step();
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        pop_result(tag);
        chk_scan({tag, "_commit"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_h = 0; m_t = 0; m_o = 0;
        rst   = 1'b1;
        value = 8'd0;
        mode  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dp", 32'(dp), 32'd1);
        rst = 1'b0;
        run("zero_frame", 16);

        drive_value(8'd123);
        run_conversion("v123");
        run("v123_frame", 16);

        // 255 then 7 after the third shift edge: 255 commits, 7 follows at once.
        drive_value(8'd255);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("v255_busy_hi", 32'(busy), 32'd1);
            chk_scan("v255_hold");
        end
        drive_value(8'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("v255_busy_hi2", 32'(busy), 32'd1);
            chk_scan("v255_hold2");
        end
        step();
        chk("v255_busy_lo", 32'(busy), 32'd0);
        pop_result("v255");
        chk_scan("v255_commit");
        run_conversion("v7");

        run("scan_wrap", 20);

        mode = 1'b1;
        run("mode1", 16);
        mode = 1'b0;
        run("mode0", 16);

        drive_value(8'd5);
        run_conversion("v5");
        run("v5_frame", 16);

        drive_value(8'd200);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_scan("v200_pre");
        end
        rst = 1'b1;
        step();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        q_exp.delete();
        m_h = 0; m_t = 0; m_o = 0;
        rst = 1'b0;
        drive_value(8'd200);
        run_conversion("v200_rerun");
        run("v200_frame", 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
